// File: rtl/cvxif_mac4b_instr_pkg.sv
// Shared types for the mac4b CV-X-IF result path: buffered result entry
// and the per-instruction commit status.
package cvxif_mac4b_instr_pkg;

    // Upper bound on the instruction id width; narrower ids are zero-extended.
    localparam int unsigned MAX_ID_W = 8;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_PENDING   = 2'd0,
        ST_COMMITTED = 2'd1,
        ST_KILLED    = 2'd2
    } commit_status_e;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [REG_W-1:0]    rd;
        logic [DATA_W-1:0]   data;
    } entry_t;

endpackage

// File: rtl/cvxif_mac4b_commit_tracker.sv
// Per-id commit status table. A commit only lands on a PENDING id; a clear
// (entry popped or bypassed) returns the id to PENDING and wins over a
// same-cycle commit to the same id.
module cvxif_mac4b_commit_tracker
    import cvxif_mac4b_instr_pkg::*;
#(
    parameter int unsigned ID_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    input  logic            clear_valid_i,
    input  logic [ID_W-1:0] clear_id_i,
    output commit_status_e  status_o [2**ID_W]
);

    localparam int unsigned NUM_IDS = 2**ID_W;

    commit_status_e status_q [NUM_IDS];

    // Status update: commit first, then clear so a retiring id ends PENDING.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_IDS; i++) begin
                status_q[i] <= ST_PENDING;
            end
        end else begin
            if (commit_valid_i && (status_q[commit_id_i] == ST_PENDING)) begin
                status_q[commit_id_i] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
            end
            if (clear_valid_i) begin
                status_q[clear_id_i] <= ST_PENDING;
            end
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/cvxif_mac4b_result_buffer.sv
// In-order result buffer between the mac4b datapath and the CV-X-IF result
// channel. Entries leave only once their id is committed; killed heads are
// dropped silently. Optional same-cycle bypass of an empty buffer is enabled
// with the macro CVXIF_MAC4B_RESBUF_BYPASS_EN.
module cvxif_mac4b_result_buffer
    import cvxif_mac4b_instr_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ID_W-1:0]   in_id_i,
    input  logic [REG_W-1:0]  in_rd_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              commit_valid_i,
    input  logic [ID_W-1:0]   commit_id_i,
    input  logic              commit_kill_i,
    output logic              x_result_valid_o,
    input  logic              x_result_ready_i,
    output logic [ID_W-1:0]   x_result_id_o,
    output logic [REG_W-1:0]  x_result_rd_o,
    output logic [DATA_W-1:0] x_result_data_o,
    output logic              x_result_we_o,
    output logic              x_result_exc_o,
    output logic [5:0]        x_result_exccode_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    entry_t           head;
    logic [ID_W-1:0]  head_id;
    commit_status_e   status [2**ID_W];
    logic             not_empty;
    logic             head_valid;
    logic             drop;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             clear_valid;
    logic [ID_W-1:0]  clear_id;

    assign head       = mem[rd_ptr];
    assign head_id    = ID_W'(head.id);
    assign not_empty  = (count != '0);
    assign head_valid = not_empty && (status[head_id] == ST_COMMITTED);
    assign drop       = not_empty && (status[head_id] == ST_KILLED);
    assign in_ready_o = (count < CNT_FULL);
    assign push_req   = in_valid_i && in_ready_o;

`ifdef CVXIF_MAC4B_RESBUF_BYPASS_EN
    logic in_committed;
    // A same-cycle commit counts only if the tracker would accept it.
    assign in_committed = (status[in_id_i] == ST_COMMITTED) ||
                          ((status[in_id_i] == ST_PENDING) && commit_valid_i &&
                           (commit_id_i == in_id_i) && !commit_kill_i);
    assign bypass = push_req && !not_empty && in_committed && x_result_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push        = push_req && !bypass;
    assign pop         = (head_valid && x_result_ready_i) || drop;
    assign clear_valid = pop || bypass;
    assign clear_id    = bypass ? in_id_i : head_id;

    cvxif_mac4b_commit_tracker #(
        .ID_W (ID_W)
    ) u_tracker (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .clear_valid_i  (clear_valid),
        .clear_id_i     (clear_id),
        .status_o       (status)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{id: MAX_ID_W'(in_id_i), rd: in_rd_i, data: in_data_i};
        end
    end

    // Result mux: committed head, else the bypassed input; zero when idle.
    always_comb begin
        x_result_valid_o = 1'b0;
        x_result_id_o    = '0;
        x_result_rd_o    = '0;
        x_result_data_o  = '0;
        if (head_valid) begin
            x_result_valid_o = 1'b1;
            x_result_id_o    = head_id;
            x_result_rd_o    = head.rd;
            x_result_data_o  = head.data;
        end
`ifdef CVXIF_MAC4B_RESBUF_BYPASS_EN
        else if (bypass) begin
            x_result_valid_o = 1'b1;
            x_result_id_o    = in_id_i;
            x_result_rd_o    = in_rd_i;
            x_result_data_o  = in_data_i;
        end
`endif
    end

    assign x_result_we_o      = x_result_valid_o;
    assign x_result_exc_o     = 1'b0;
    assign x_result_exccode_o = '0;

    logic dup_id;
    // Flags a push whose id already sits somewhere in the buffer.
    always_comb begin
        dup_id = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (mem[rd_ptr + PTR_W'(i)].id == MAX_ID_W'(in_id_i))) begin
                dup_id = 1'b1;
            end
        end
    end

    dup_push_a: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !dup_id)
        else $error("push of an id already resident in the result buffer");

endmodule

// File: tb/tb_cvxif_mac4b_result_buffer.sv
module tb_cvxif_mac4b_result_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned NUM_IDS = 8;
    localparam int PEND = 0;
    localparam int COMM = 1;
    localparam int KILL = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  in_id_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic [31:0] in_data_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [2:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        x_result_valid_o;
    logic        x_result_ready_i = 1'b0;
    logic [2:0]  x_result_id_o;
    logic [4:0]  x_result_rd_o;
    logic [31:0] x_result_data_o;
    logic        x_result_we_o;
    logic        x_result_exc_o;
    logic [5:0]  x_result_exccode_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cvxif_mac4b_result_buffer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_id_i            (in_id_i),
        .in_rd_i            (in_rd_i),
        .in_data_i          (in_data_i),
        .commit_valid_i     (commit_valid_i),
        .commit_id_i        (commit_id_i),
        .commit_kill_i      (commit_kill_i),
        .x_result_valid_o   (x_result_valid_o),
        .x_result_ready_i   (x_result_ready_i),
        .x_result_id_o      (x_result_id_o),
        .x_result_rd_o      (x_result_rd_o),
        .x_result_data_o    (x_result_data_o),
        .x_result_we_o      (x_result_we_o),
        .x_result_exc_o     (x_result_exc_o),
        .x_result_exccode_o (x_result_exccode_o)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        cv;
        logic [2:0]  cid;
        logic        ck;
        logic        rdy;
        logic        ev;
        logic [2:0]  eid;
        logic [4:0]  erd;
        logic [31:0] ed;
        int          ecnt;
    } vec_t;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t tbl [14];
    ent_t q [$];
    int   st [NUM_IDS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string t, input logic ev, input logic [2:0] eid,
                           input logic [4:0] erd, input logic [31:0] ed);
        chk({t, ".valid"},   64'(x_result_valid_o),   64'(ev));
        chk({t, ".id"},      64'(x_result_id_o),      64'(eid));
        chk({t, ".rd"},      64'(x_result_rd_o),      64'(erd));
        chk({t, ".data"},    64'(x_result_data_o),    64'(ed));
        chk({t, ".we"},      64'(x_result_we_o),      64'(ev));
        chk({t, ".exc"},     64'(x_result_exc_o),     64'd0);
        chk({t, ".exccode"}, 64'(x_result_exccode_o), 64'd0);
    endtask

    task automatic drive(input logic iv, input logic [2:0] id, input logic [4:0] rd,
                         input logic [31:0] d, input logic cv, input logic [2:0] cid,
                         input logic ck, input logic rdy);
        in_valid_i       = iv;
        in_id_i          = id;
        in_rd_i          = rd;
        in_data_i        = d;
        commit_valid_i   = cv;
        commit_id_i      = cid;
        commit_kill_i    = ck;
        x_result_ready_i = rdy;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0, rdy);
    endtask

    function automatic bit resident(input logic [2:0] id);
        foreach (q[k]) if (q[k].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pulse_reset();
        #2;
        rst_ni = 1'b0;
        idle(1'b0);
        #1;
        chk_out("rst", 1'b0, 3'd0, 5'd0, 32'd0);
        chk("rst.count", 64'(dut.count), 64'd0);
        chk("rst.in_ready", 64'(in_ready_o), 64'd1);
        step();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: single commit, early commit, kill of the head.
        tbl[0]  = '{1, 3'd2, 5'd7, 32'h123,  0, 3'd0, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[1]  = '{0, 3'd0, 5'd0, 32'h0,    1, 3'd2, 0, 1,  0, 3'd0, 5'd0, 32'h0,   1};
        tbl[2]  = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  1, 3'd2, 5'd7, 32'h123, 1};
        tbl[3]  = '{0, 3'd0, 5'd0, 32'h0,    1, 3'd1, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[4]  = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[5]  = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[6]  = '{1, 3'd1, 5'd3, 32'hA5A5, 0, 3'd0, 0, 0,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[7]  = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  1, 3'd1, 5'd3, 32'hA5A5, 1};
        tbl[8]  = '{1, 3'd0, 5'd1, 32'h10,   0, 3'd0, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};
        tbl[9]  = '{1, 3'd1, 5'd2, 32'h11,   1, 3'd0, 1, 1,  0, 3'd0, 5'd0, 32'h0,   1};
        tbl[10] = '{1, 3'd2, 5'd3, 32'h12,   1, 3'd1, 0, 1,  0, 3'd0, 5'd0, 32'h0,   2};
        tbl[11] = '{0, 3'd0, 5'd0, 32'h0,    1, 3'd2, 0, 1,  1, 3'd1, 5'd2, 32'h11,  2};
        tbl[12] = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  1, 3'd2, 5'd3, 32'h12,  1};
        tbl[13] = '{0, 3'd0, 5'd0, 32'h0,    0, 3'd0, 0, 1,  0, 3'd0, 5'd0, 32'h0,   0};

        // Reset state.
        step();
        step();
        @(negedge clk_i);
        chk_out("reset", 1'b0, 3'd0, 5'd0, 32'd0);
        chk("reset.in_ready", 64'(in_ready_o), 64'd1);
        chk("reset.count", 64'(dut.count), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].rd, tbl[i].d,
                  tbl[i].cv, tbl[i].cid, tbl[i].ck, tbl[i].rdy);
            @(negedge clk_i);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].eid, tbl[i].erd, tbl[i].ed);
            chk($sformatf("tbl[%0d].count", i), 64'(dut.count), 64'(tbl[i].ecnt));
            chk($sformatf("tbl[%0d].in_ready", i), 64'(in_ready_o), 64'd1);
            step();
        end

        // Fill to DEPTH with the core stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(4 + i), 5'(i), 32'h40 + 32'(i), 1'b0, 3'd0, 1'b0, 1'b0);
            @(negedge clk_i);
            chk($sformatf("fill[%0d].in_ready", i), 64'(in_ready_o), 64'd1);
            step();
        end
        drive(1'b1, 3'd0, 5'd9, 32'hBAD, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("full.in_ready", 64'(in_ready_o), 64'd0);
        step();
        drive(1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("full.ignored.count", 64'(dut.count), 64'd4);
        step();
        idle(1'b1);
        @(negedge clk_i);
        chk_out("full.head", 1'b1, 3'd4, 5'd0, 32'h40);
        chk("full.head.in_ready", 64'(in_ready_o), 64'd0);
        step();
        idle(1'b0);
        @(negedge clk_i);
        chk("after_pop.in_ready", 64'(in_ready_o), 64'd1);
        chk("after_pop.count", 64'(dut.count), 64'd3);
        for (int i = 5; i < 8; i++) begin
            step();
            drive(1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 3'(i), 1'b0, 1'b0);
        end
        step();
        idle(1'b1);
        for (int k = 0; k < 20 && dut.count != 0; k++) step();
        chk("drain.count", 64'(dut.count), 64'd0);

        // Ten back-to-back push+commit pairs, pointers wrap twice.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'(k), 5'(k), 32'h100 + 32'(k), 1'b1, 3'(k), 1'b0, k != 0);
            @(negedge clk_i);
            if (k > 0) begin
                chk_out($sformatf("wrap[%0d]", k), 1'b1, 3'(k - 1), 5'(k - 1), 32'h100 + 32'(k - 1));
                chk($sformatf("wrap[%0d].count", k), 64'(dut.count), 64'd1);
            end else begin
                chk_out("wrap[0]", 1'b0, 3'd0, 5'd0, 32'd0);
            end
            step();
        end
        idle(1'b1);
        @(negedge clk_i);
        chk_out("wrap.last", 1'b1, 3'd1, 5'd9, 32'h109);
        step();
        @(negedge clk_i);
        chk("wrap.end.count", 64'(dut.count), 64'd0);
        step();

        // Stall: offered result must hold while ready is low.
        drive(1'b1, 3'd3, 5'd9, 32'hDEADBEEF, 1'b1, 3'd3, 1'b0, 1'b0);
        step();
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 3'(4 + s), 5'($urandom), $urandom, 1'b1, 3'(5 + s), 1'b0, 1'b0);
            @(negedge clk_i);
            chk_out($sformatf("stall[%0d]", s), 1'b1, 3'd3, 5'd9, 32'hDEADBEEF);
            step();
        end
        pulse_reset();

        // Tracker must be cleared: id 3 is no longer committed.
        drive(1'b1, 3'd3, 5'd1, 32'h33, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        idle(1'b1);
        @(negedge clk_i);
        chk_out("post_rst", 1'b0, 3'd0, 5'd0, 32'd0);
        chk("post_rst.count", 64'(dut.count), 64'd1);
        step();
        pulse_reset();

`ifdef CVXIF_MAC4B_RESBUF_BYPASS_EN
        drive(1'b1, 3'd3, 5'd4, 32'hCAFE, 1'b1, 3'd3, 1'b0, 1'b1);
        @(negedge clk_i);
        chk_out("bypass", 1'b1, 3'd3, 5'd4, 32'hCAFE);
        chk("bypass.count", 64'(dut.count), 64'd0);
        step();
        idle(1'b1);
        @(negedge clk_i);
        chk("bypass.after.count", 64'(dut.count), 64'd0);
        chk_out("bypass.after", 1'b0, 3'd0, 5'd0, 32'd0);
        step();
`endif

        // Randomized run against the queue + status-table model.
        q.delete();
        for (int i = 0; i < NUM_IDS; i++) st[i] = PEND;
        for (int c = 0; c < 600; c++) begin
            logic        iv, cv, ck, rdy, ev, byp, drop, pop, can_push;
            logic [2:0]  id, cid, eid;
            logic [4:0]  rd, erd;
            logic [31:0] d, ed;
            iv  = 1'($urandom % 2);
            do id = 3'($urandom); while (resident(id));
            rd  = 5'($urandom);
            d   = $urandom;
            cv  = ($urandom % 3) == 0;
            cid = 3'($urandom);
            ck  = ($urandom % 4) == 0;
            rdy = ($urandom % 4) != 0;
            drive(iv, id, rd, d, cv, cid, ck, rdy);

            ev = 1'b0; byp = 1'b0; eid = '0; erd = '0; ed = '0;
            if (q.size() > 0 && st[q[0].id] == COMM) begin
                ev = 1'b1; eid = q[0].id; erd = q[0].rd; ed = q[0].data;
            end
`ifdef CVXIF_MAC4B_RESBUF_BYPASS_EN
            else if (q.size() == 0 && iv && rdy &&
                     (st[id] == COMM || (st[id] == PEND && cv && cid == id && !ck))) begin
                ev = 1'b1; byp = 1'b1; eid = id; erd = rd; ed = d;
            end
`endif
            @(negedge clk_i);
            chk_out($sformatf("rnd[%0d]", c), ev, eid, erd, ed);
            chk($sformatf("rnd[%0d].in_ready", c), 64'(in_ready_o), 64'(q.size() < DEPTH));

            drop     = q.size() > 0 && st[q[0].id] == KILL;
            pop      = drop || (ev && rdy && !byp);
            can_push = q.size() < DEPTH;
            if (cv && st[cid] == PEND) st[cid] = ck ? KILL : COMM;
            if (pop) begin
                st[q[0].id] = PEND;
                void'(q.pop_front());
            end
            if (byp) st[id] = PEND;
            else if (iv && can_push) q.push_back('{id, rd, d});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
